board_material_eval: RTL

Fabric-side client of the on-chip RAM second port (`s2_*`) of the system interconnect. It polls a command mailbox in that RAM that software writes. On a go request it reads a packed 64-square board, computes the signed material balance and piece counts, writes a result word and a status word back, then clears the mailbox. It is the hardware evaluation stage that consumes the board images software places in shared RAM.

---
 rtl/board_material_eval.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/board_material_eval.sv
// board_material_eval
//   Polls a command mailbox in shared RAM through the s2_* port. When the go
//   bit (BASE+0 bit 31) is set, reads the 64-square board at BASE+1..BASE+8,
//   computes signed material balance and per-colour piece counts, writes the
//   score to BASE+9 and the status to BASE+10, then clears BASE+0.
//
//   Optional feature: define BOARD_EVAL_LEGALITY_EN to enable the king-count
//   and invalid-code checks that drive `error` and status bit 30.
//
// Parameters
//   BASE         mailbox word address (uses BASE..BASE+10)
//   RD_LAT       RAM read latency, 1 or 2
//   POLL_CYCLES  idle cycles between mailbox polls (>= 1)
//
// Ports
//   system_ref_clk_clk      clock
//   system_ref_reset_reset  synchronous active-high reset
//   s2_address/s2_chipselect/s2_clken/s2_write/s2_writedata/s2_byteenable
//                           RAM master outputs (registered)
//   s2_readdata             RAM read data, valid RD_LAT cycles after issue
//   busy                    high from go detection until done
//   done                    one-cycle pulse when an evaluation completes
//   score                   signed score of the last evaluation
//   error                   legality flag of the last evaluation
module board_material_eval #(
  parameter logic [11:0] BASE        = 12'h000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned POLL_CYCLES = 256
) (
  input  logic        system_ref_clk_clk,
  input  logic        system_ref_reset_reset,
  output logic [11:0] s2_address,
  output logic        s2_chipselect,
  output logic        s2_clken,
  output logic        s2_write,
  output logic [31:0] s2_writedata,
  output logic [3:0]  s2_byteenable,
  input  logic [31:0] s2_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] score,
  output logic        error
);

  localparam int unsigned     PW          = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  // IDLE spans exactly POLL_CYCLES cycles: reload with N-1, leave at 0.
  localparam logic [PW-1:0]   POLL_RELOAD = PW'(POLL_CYCLES - 1);
  localparam logic            LAT_LOAD    = (RD_LAT > 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_RD, S_CMD_WAIT, S_BRD_RD, S_DRAIN, S_WR_SCORE, S_WR_STATUS, S_CLR_CMD
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          lat_q, lat_d;
  logic [2:0]    idx_q, idx_d, capn_q, capn_d;
  logic [1:0]    vld_q, vld_d;
  logic          cap;
  logic [31:0]   acc_q, acc_d, score_q, score_d;
  logic [7:0]    wcnt_q, wcnt_d, bcnt_q, bcnt_d, tag_q, tag_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, legal_err;
  logic          cs_q, cs_d, wr_q, wr_d;
  logic [11:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic [3:0]    nib;
  logic [31:0]   word_score;
  logic [3:0]    word_wcnt, word_bcnt;
`ifdef BOARD_EVAL_LEGALITY_EN
  logic [6:0]    wk_q, wk_d, bk_q, bk_d;
  logic          inv_q, inv_d;
  logic [3:0]    word_wk, word_bk;
  logic          word_inv;
`endif

  function automatic logic [31:0] piece_weight(input logic [2:0] t);
    case (t)
      3'd1:    piece_weight = 32'd100;
      3'd2:    piece_weight = 32'd320;
      3'd3:    piece_weight = 32'd330;
      3'd4:    piece_weight = 32'd500;
      3'd5:    piece_weight = 32'd900;
      default: piece_weight = 32'd0;
    endcase
  endfunction

  // Per-word evaluation of the captured board word (8 nibble lookups).
  always_comb begin
    nib        = '0;
    word_score = '0;
    word_wcnt  = '0;
    word_bcnt  = '0;
`ifdef BOARD_EVAL_LEGALITY_EN
    word_wk    = '0;
    word_bk    = '0;
    word_inv   = 1'b0;
`endif
    for (int unsigned n = 0; n < 8; n++) begin
      nib = s2_readdata[4*n +: 4];
      if (nib[3]) word_score = word_score - piece_weight(nib[2:0]);
      else        word_score = word_score + piece_weight(nib[2:0]);
      if (nib[2:0] != 3'd0 && nib[2:0] != 3'd7) begin
        if (nib[3]) word_bcnt = word_bcnt + 4'd1;
        else        word_wcnt = word_wcnt + 4'd1;
      end
`ifdef BOARD_EVAL_LEGALITY_EN
      if (nib[2:0] == 3'd6) begin
        if (nib[3]) word_bk = word_bk + 4'd1;
        else        word_wk = word_wk + 4'd1;
      end
      if (nib[2:0] == 3'd7) word_inv = 1'b1;
`endif
    end
  end

`ifdef BOARD_EVAL_LEGALITY_EN
  assign legal_err = (wk_q != 7'd1) || (bk_q != 7'd1) || inv_q;
`else
  assign legal_err = 1'b0;
`endif

  // Read data for a board issue arrives RD_LAT cycles later.
  assign cap = (RD_LAT > 1) ? vld_q[1] : vld_q[0];

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    capn_d  = capn_q;
    vld_d   = {vld_q[0], state_q == S_BRD_RD};
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    score_d = score_q;
    err_d   = err_q;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef BOARD_EVAL_LEGALITY_EN
    wk_d    = wk_q;
    bk_d    = bk_q;
    inv_d   = inv_q;
`endif

    if (cap) begin
      acc_d  = acc_q + word_score;
      wcnt_d = wcnt_q + {4'd0, word_wcnt};
      bcnt_d = bcnt_q + {4'd0, word_bcnt};
      capn_d = capn_q + 3'd1;
`ifdef BOARD_EVAL_LEGALITY_EN
      wk_d   = wk_q + {3'd0, word_wk};
      bk_d   = bk_q + {3'd0, word_bk};
      inv_d  = inv_q | word_inv;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (poll_q == '0) state_d = S_CMD_RD;
        else              poll_d  = poll_q - 1'b1;
      end
      S_CMD_RD: begin
        state_d = S_CMD_WAIT;
        lat_d   = LAT_LOAD;
      end
      S_CMD_WAIT: begin
        if (lat_q) begin
          lat_d = 1'b0;
        end else if (s2_readdata[31]) begin
          tag_d   = s2_readdata[7:0];
          acc_d   = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          capn_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_BRD_RD;
`ifdef BOARD_EVAL_LEGALITY_EN
          wk_d    = '0;
          bk_d    = '0;
          inv_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
          poll_d  = POLL_RELOAD;
        end
      end
      S_BRD_RD: begin
        if (idx_q == 3'd7) state_d = S_DRAIN;
        else               idx_d   = idx_q + 3'd1;
      end
      S_DRAIN: begin
        if (cap && capn_q == 3'd7) state_d = S_WR_SCORE;
      end
      S_WR_SCORE: begin
        score_d = acc_q;
        err_d   = legal_err;
        state_d = S_WR_STATUS;
      end
      S_WR_STATUS: state_d = S_CLR_CMD;
      S_CLR_CMD: begin
        state_d = S_IDLE;
        poll_d  = POLL_RELOAD;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with
    // the state register; anything not driven here holds its last value.
    case (state_d)
      S_CMD_RD: begin
        cs_d   = 1'b1;
        addr_d = BASE;
        be_d   = '1;
      end
      S_BRD_RD: begin
        cs_d   = 1'b1;
        addr_d = BASE + 12'(idx_d) + 12'd1;
        be_d   = '1;
      end
      S_WR_SCORE: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = BASE + 12'd9;
        wdata_d = acc_d;
        be_d    = '1;
      end
      S_WR_STATUS: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = BASE + 12'd10;
        wdata_d = {1'b1, err_d, 6'b0, wcnt_q, bcnt_q, tag_q};
        be_d    = '1;
      end
      S_CLR_CMD: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = BASE;
        wdata_d = '0;
        be_d    = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge system_ref_clk_clk) begin
    if (system_ref_reset_reset) begin
      state_q <= S_IDLE;
      poll_q  <= POLL_RELOAD;
      lat_q   <= 1'b0;
      idx_q   <= '0;
      capn_q  <= '0;
      vld_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      tag_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      score_q <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
`ifdef BOARD_EVAL_LEGALITY_EN
      wk_q    <= '0;
      bk_q    <= '0;
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      capn_q  <= capn_d;
      vld_q   <= vld_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      score_q <= score_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
`ifdef BOARD_EVAL_LEGALITY_EN
      wk_q    <= wk_d;
      bk_q    <= bk_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign s2_address    = addr_q;
  assign s2_chipselect = cs_q;
  assign s2_clken      = 1'b1;
  assign s2_write      = wr_q;
  assign s2_writedata  = wdata_q;
  assign s2_byteenable = be_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign score         = score_q;
  assign error         = err_q;

endmodule
